// File: rtl/esfa_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : esfa_cmd_sequencer
// Desc   : Host command FIFO and single-issue sequencer for the ESFA array bus.
// Rev    : 1.0  initial release
// ============================================================================
module esfa_cmd_sequencer #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] IDLE_OP    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [7:0]  cmd_index,
  input  logic [7:0]  cmd_value,
  input  logic [7:0]  cmd_meta,
  input  logic        cmd_is_meta,
  output logic [7:0]  new_index,
  output logic [7:0]  new_value,
  output logic [7:0]  metadata,
  output logic        isMetadata,
  output logic [7:0]  selector,
  input  logic        arr_done,
  input  logic        arr_bool,
  input  logic [7:0]  arr_value,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_bool,
  output logic [7:0]  rsp_value,
  output logic        rsp_timeout,
  output logic [15:0] rsp_cycles,
  output logic        busy
);

  localparam int            c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);
  localparam logic [15:0]   c_TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]   c_CYC_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  logic [33:0]   r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  state_t        r_state;
  logic [15:0]   r_cyc;
  logic [7:0]    r_sel;
  logic [7:0]    r_idx;
  logic [7:0]    r_val;
  logic [7:0]    r_meta;
  logic          r_is_meta;
  logic          r_rsp_valid;
  logic          r_rsp_bool;
  logic [7:0]    r_rsp_value;
  logic          r_rsp_timeout;
  logic [15:0]   r_rsp_cycles;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [33:0]   w_head;
  logic [15:0]   w_cyc_inc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_cyc_inc = (r_cyc == c_CYC_MAX) ? c_CYC_MAX : r_cyc + 16'd1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {cmd_op, cmd_index, cmd_value, cmd_meta, cmd_is_meta};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cyc         <= '0;
      r_sel         <= IDLE_OP;
      r_idx         <= '0;
      r_val         <= '0;
      r_meta        <= '0;
      r_is_meta     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_bool    <= 1'b0;
      r_rsp_value   <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_cycles  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_sel, r_idx, r_val, r_meta, r_is_meta} <= w_head;
            r_state <= S_ISSUE;
          end else begin
            r_sel <= IDLE_OP;
          end
        end
        S_ISSUE: begin
          r_cyc   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cyc <= w_cyc_inc;
          // A done arriving on the timeout cycle still counts as a real result.
          if (arr_done) begin
            r_rsp_bool    <= arr_bool;
            r_rsp_value   <= arr_value;
            r_rsp_timeout <= 1'b0;
            r_rsp_cycles  <= w_cyc_inc;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_cyc == c_TO_LAST) begin
            r_rsp_bool    <= 1'b0;
            r_rsp_value   <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_cycles  <= w_cyc_inc;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_sel       <= IDLE_OP;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = !w_full;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign selector    = r_sel;
  assign new_index   = r_idx;
  assign new_value   = r_val;
  assign metadata    = r_meta;
  assign isMetadata  = r_is_meta;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_bool    = r_rsp_bool;
  assign rsp_value   = r_rsp_value;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_cycles  = r_rsp_cycles;

endmodule
`default_nettype wire

// File: tb/tb_esfa_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_esfa_cmd_sequencer
// Desc   : Directed plus randomized bench with a timing-rule reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_esfa_cmd_sequencer;

  localparam int         c_DEPTH = 4;
  localparam int         c_TO    = 8;
  localparam logic [7:0] c_IDLE  = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_is_meta;
  logic [7:0]  cmd_op, cmd_index, cmd_value, cmd_meta;
  logic [7:0]  new_index, new_value, metadata, selector;
  logic        isMetadata;
  logic        arr_done, arr_bool;
  logic [7:0]  arr_value;
  logic        rsp_valid, rsp_ready, rsp_bool, rsp_timeout, busy;
  logic [7:0]  rsp_value;
  logic [15:0] rsp_cycles;

  always #5 clk = ~clk;

  esfa_cmd_sequencer #(
    .FIFO_DEPTH (c_DEPTH),
    .TIMEOUT    (c_TO),
    .IDLE_OP    (c_IDLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_index   (cmd_index),
    .cmd_value   (cmd_value),
    .cmd_meta    (cmd_meta),
    .cmd_is_meta (cmd_is_meta),
    .new_index   (new_index),
    .new_value   (new_value),
    .metadata    (metadata),
    .isMetadata  (isMetadata),
    .selector    (selector),
    .arr_done    (arr_done),
    .arr_bool    (arr_bool),
    .arr_value   (arr_value),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_bool    (rsp_bool),
    .rsp_value   (rsp_value),
    .rsp_timeout (rsp_timeout),
    .rsp_cycles  (rsp_cycles),
    .busy        (busy)
  );

  // d = WAIT cycle on which the array reports done (beyond c_TO means never in time)
  typedef struct {
    logic [7:0] op, idx, val, meta;
    logic       ism;
    int         d;
    bit         ipulse;
    int         tp;
  } cmd_t;

  cmd_t       q[$];
  cmd_t       cur;
  bit         inflight, rdy_prev;
  int         t_now, t_iss, t_rsp, t_n, idle_from;
  logic [7:0] cap_val;
  logic       cap_bool;
  int         total, bad;
  int         p_valid, p_ready, d_fix, ip_mode;
  bit         hold, force_cmd, force_arr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t_now, obs, exp);
    end
  endtask

  task automatic clear_cur();
    cur.op = '0; cur.idx = '0; cur.val = '0; cur.meta = '0; cur.ism = 1'b0;
    cur.d = 0; cur.ipulse = 1'b0; cur.tp = 0;
  endtask

  // Model update and checks at a falling edge, from the rules: a queued command
  // issues one cycle after the engine is idle, answers after min(d,TIMEOUT) WAIT cycles.
  task automatic observe();
    if (inflight && rdy_prev && (t_now - 1) >= t_rsp) begin
      inflight  = 1'b0;
      idle_from = t_now;
    end
    if (!inflight && q.size() > 0 && (t_now - 1) >= idle_from && q[0].tp <= t_now - 2) begin
      cur      = q.pop_front();
      inflight = 1'b1;
      t_iss    = t_now;
      t_n      = (cur.d < c_TO) ? cur.d : c_TO;
      t_rsp    = t_iss + t_n + 1;
    end
    chk("selector",   selector,   inflight ? cur.op : c_IDLE);
    chk("new_index",  new_index,  cur.idx);
    chk("new_value",  new_value,  cur.val);
    chk("metadata",   metadata,   cur.meta);
    chk("isMetadata", isMetadata, cur.ism);
    chk("cmd_ready",  cmd_ready,  q.size() < c_DEPTH);
    chk("busy",       busy,       inflight || q.size() > 0);
    chk("rsp_valid",  rsp_valid,  inflight && t_now >= t_rsp);
    if (inflight && t_now >= t_rsp) begin
      chk("rsp_timeout", rsp_timeout, cur.d > c_TO);
      chk("rsp_value",   rsp_value,   (cur.d > c_TO) ? 8'h00 : cap_val);
      chk("rsp_bool",    rsp_bool,    (cur.d > c_TO) ? 1'b0 : cap_bool);
      chk("rsp_cycles",  rsp_cycles,  t_n);
    end
  endtask

  task automatic drive();
    cmd_t e;
    arr_value = 8'($urandom);
    arr_bool  = 1'($urandom);
    arr_done  = 1'b0;
    if (inflight && t_now == t_iss) begin
      arr_done = cur.ipulse;
    end else if (inflight && (t_now - t_iss) == cur.d && t_now < t_rsp) begin
      if (force_arr) begin
        arr_value = 8'h5A;
        arr_bool  = 1'b1;
      end
      arr_done = 1'b1;
      cap_val  = arr_value;
      cap_bool = arr_bool;
    end else if (!inflight || t_now >= t_rsp) begin
      arr_done = 1'($urandom_range(0, 1));
    end
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 99) < p_ready);
    rdy_prev  = rsp_ready;
    cmd_valid   = force_cmd || ($urandom_range(0, 99) < p_valid);
    cmd_op      = force_cmd ? 8'h01 : 8'($urandom_range(1, 255));
    cmd_index   = force_cmd ? 8'h03 : 8'($urandom);
    cmd_value   = force_cmd ? 8'h5A : 8'($urandom);
    cmd_meta    = force_cmd ? 8'h00 : 8'($urandom);
    cmd_is_meta = force_cmd ? 1'b0  : 1'($urandom);
    if (cmd_valid && q.size() < c_DEPTH) begin
      e.op = cmd_op; e.idx = cmd_index; e.val = cmd_value; e.meta = cmd_meta; e.ism = cmd_is_meta;
      e.d      = (d_fix > 0) ? d_fix : $urandom_range(1, c_TO + 3);
      e.ipulse = (ip_mode < 0) ? 1'($urandom_range(0, 1)) : (ip_mode != 0);
      e.tp     = t_now;
      q.push_back(e);
    end
    force_cmd = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      t_now++;
      observe();
      drive();
    end
  endtask

  task automatic wait_rsp(input int limit);
    int k = 0;
    while (!rsp_valid && k < limit) begin
      run(1);
      k++;
    end
    total++;
    assert (rsp_valid === 1'b1) else begin
      bad++;
      $error("FAIL wait_rsp observed=no response expected=response within %0d cycles", limit);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; cmd_valid = 1'b0; arr_done = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_selector",    selector,    c_IDLE);
    chk("rst_new_index",   new_index,   8'h00);
    chk("rst_new_value",   new_value,   8'h00);
    chk("rst_metadata",    metadata,    8'h00);
    chk("rst_isMetadata",  isMetadata,  1'b0);
    chk("rst_rsp_valid",   rsp_valid,   1'b0);
    chk("rst_rsp_bool",    rsp_bool,    1'b0);
    chk("rst_rsp_value",   rsp_value,   8'h00);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rsp_cycles",  rsp_cycles,  16'h0000);
    chk("rst_busy",        busy,        1'b0);
    q.delete();
    inflight = 1'b0;
    rdy_prev = 1'b0;
    clear_cur();
    repeat (2) begin
      @(negedge clk);
      t_now++;
    end
    reset     = 1'b1;
    idle_from = t_now;
    observe();
    drive();
  endtask

  initial begin
    int k;
    total = 0; bad = 0; t_now = 0; t_iss = 0; t_rsp = 0; t_n = 0; idle_from = 0;
    cap_val = '0; cap_bool = 1'b0;
    p_valid = 0; p_ready = 100; d_fix = 0; ip_mode = 0;
    hold = 1'b0; force_cmd = 1'b0; force_arr = 1'b0;
    cmd_op = '0; cmd_index = '0; cmd_value = '0; cmd_meta = '0; cmd_is_meta = 1'b0;
    arr_bool = 1'b0; arr_value = '0;
    do_reset();

    // Single command, done on the second WAIT cycle with value 5A / bool 1
    force_cmd = 1'b1; d_fix = 2; force_arr = 1'b1;
    wait_rsp(20);
    run(6);
    force_arr = 1'b0;

    // Five back-to-back commands with a stalled array: each one times out
    p_valid = 100; d_fix = 100;
    run(5);
    p_valid = 0;
    run(70);

    // Response backpressure with array done pulses and more commands queuing
    d_fix = 3; force_cmd = 1'b1; hold = 1'b1;
    wait_rsp(20);
    p_valid = 30;
    run(10);
    p_valid = 0; hold = 1'b0; p_ready = 100;
    run(30);

    // Done during the ISSUE cycle must be ignored
    ip_mode = 1; d_fix = 3; p_valid = 100;
    run(3);
    p_valid = 0;
    run(30);
    ip_mode = 0;

    // Reset while a command waits and two more are queued
    d_fix = 100; p_valid = 100;
    run(3);
    p_valid = 0;
    k = 0;
    while (!(inflight && t_now > t_iss && t_now < t_rsp && q.size() == 2) && k < 20) begin
      run(1);
      k++;
    end
    do_reset();
    run(12);

    // Randomized traffic
    ip_mode = -1; d_fix = 0;
    for (int s = 0; s < 40; s++) begin
      p_valid = $urandom_range(10, 90);
      p_ready = $urandom_range(10, 100);
      run(50);
    end
    p_valid = 0; p_ready = 100;
    run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
